// File: rtl/frame_accum.sv
// frame_accum: reduces each framed beat stream to one beat {sum of uc_d0, beat count}; ports uc_* in, cu_sflags back, cd_* out, dc_sflags back, frm_drop pulse
module frame_accum #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] uc_d0,
  input  logic [W-1:0] uc_d1,
  input  logic [3:0]   uc_mflags,
  output logic [1:0]   cu_sflags,
  output logic [W-1:0] cd_d0,
  output logic [W-1:0] cd_d1,
  output logic [3:0]   cd_mflags,
  input  logic [1:0]   dc_sflags,
  output logic         frm_drop
);
  typedef enum logic [1:0] {ST_IDLE, ST_ACC, ST_OUT} state_t;
  localparam logic [W-1:0] ONE = 1;
  state_t state;
  logic [W-1:0] acc, cnt;
  logic uc_first, uc_last, uc_vld, dc_abt, dc_bsy, cd_vld, cu_bsy, take;
  logic unused_ok;
  assign unused_ok = ^{uc_d1, uc_mflags[3]};
  assign {uc_first, uc_last, uc_vld} = uc_mflags[2:0];
  assign {dc_abt, dc_bsy} = dc_sflags;
  assign cd_vld = state == ST_OUT;
  assign cu_bsy = cd_vld & dc_bsy;
  assign take = uc_vld & ~cu_bsy;
  assign cu_sflags = {dc_abt, cu_bsy};
  assign cd_mflags = {cd_vld & dc_bsy, cd_vld, cd_vld, cd_vld};
  always_ff @(posedge clk) begin
    frm_drop <= 1'b0;
    if (rst) begin
      state <= ST_IDLE;
      acc <= '0;
      cnt <= '0;
      cd_d0 <= '0;
      cd_d1 <= '0;
    end else if (dc_abt) begin
      state <= ST_IDLE;
      acc <= '0;
      cnt <= '0;
    end else if (take && state == ST_ACC && !uc_first) begin
      if (uc_last) begin
        cd_d0 <= acc + uc_d0;
        cd_d1 <= cnt + ONE;
        state <= ST_OUT;
      end else begin
        acc <= acc + uc_d0;
        cnt <= cnt + ONE;
      end
    end else if (take) begin
      frm_drop <= (state == ST_ACC) | ~uc_first;
      if (!uc_first) state <= ST_IDLE;
      else if (uc_last) begin
        cd_d0 <= uc_d0;
        cd_d1 <= ONE;
        state <= ST_OUT;
      end else begin
        acc <= uc_d0;
        cnt <= ONE;
        state <= ST_ACC;
      end
    end else if (cd_vld && !dc_bsy) state <= ST_IDLE;
  end
endmodule

// File: tb/tb_frame_accum.sv
// tb_frame_accum: table, corner-case and random checks of frame_accum against a frame-queue model
module tb_frame_accum;
  logic clk = 0, rst = 1, chk_en = 0;
  logic [31:0] uc_d0 = 0, uc_d1 = 0, cd_d0, cd_d1;
  logic [3:0] uc_mflags = 0, cd_mflags, d8_mflags;
  logic [1:0] dc_sflags = 0, cu_sflags, d8_cu_sflags;
  logic frm_drop, d8_drop;
  logic [7:0] d8_d0, d8_d1;
  int n_run = 0, n_fail = 0;

  always #5 clk = ~clk;

  frame_accum #(.W(32)) dut (.clk(clk), .rst(rst), .uc_d0(uc_d0), .uc_d1(uc_d1), .uc_mflags(uc_mflags),
    .cu_sflags(cu_sflags), .cd_d0(cd_d0), .cd_d1(cd_d1), .cd_mflags(cd_mflags), .dc_sflags(dc_sflags), .frm_drop(frm_drop));
  frame_accum #(.W(8)) dut8 (.clk(clk), .rst(rst), .uc_d0(uc_d0[7:0]), .uc_d1(uc_d1[7:0]), .uc_mflags(uc_mflags),
    .cu_sflags(d8_cu_sflags), .cd_d0(d8_d0), .cd_d1(d8_d1), .cd_mflags(d8_mflags), .dc_sflags(dc_sflags), .frm_drop(d8_drop));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: collects the open frame's beats in a queue and sums them on last.
  logic [31:0] fr[$];
  bit open, ov, odrop;
  logic [31:0] os, oc;

  function automatic logic [31:0] fsum();
    logic [31:0] s = 0;
    foreach (fr[i]) s += fr[i];
    return s;
  endfunction

  always @(posedge clk) begin : mdl
    bit take;
    if (rst) begin
      open = 0; fr.delete(); ov = 0; os = 0; oc = 0; odrop = 0;
    end else begin
      take = uc_mflags[0] && !(ov && dc_sflags[0]);
      odrop = 0;
      if (dc_sflags[1]) begin
        open = 0; fr.delete(); ov = 0;
      end else begin
        if (ov && !dc_sflags[0]) ov = 0;
        if (take) begin
          if (uc_mflags[2]) begin
            if (open) odrop = 1;
            fr.delete(); fr.push_back(uc_d0); open = 1;
          end else if (open) fr.push_back(uc_d0);
          else odrop = 1;
          if (open && uc_mflags[1]) begin
            os = fsum(); oc = fr.size(); ov = 1; open = 0;
          end
        end
      end
    end
  end

  always @(negedge clk) if (chk_en) begin
    chk("m_mflags", cd_mflags, {ov & dc_sflags[0], ov, ov, ov});
    chk("m_d0", cd_d0, os);
    chk("m_d1", cd_d1, oc);
    chk("m_sflags", cu_sflags, {dc_sflags[1], ov & dc_sflags[0]});
    chk("m_drop", frm_drop, odrop);
    chk("m8_mflags", d8_mflags, {ov & dc_sflags[0], ov, ov, ov});
    chk("m8_d0", d8_d0, os[7:0]);
    chk("m8_d1", d8_d1, oc[7:0]);
    chk("m8_sflags", d8_cu_sflags, {dc_sflags[1], ov & dc_sflags[0]});
    chk("m8_drop", d8_drop, odrop);
  end

  task automatic drive(input int v, f, l, input logic [31:0] d, input int b, a);
    uc_mflags = {1'b0, f[0], l[0], v[0]};
    uc_d0 = d;
    uc_d1 = $urandom;
    dc_sflags = {a[0], b[0]};
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int v, f, l;
    logic [31:0] d;
    int b, a, ev;
    logic [31:0] ed0, ed1;
    int edrop, ecb;
  } vec_t;
  vec_t tbl[29];

  initial begin
    tbl = '{
      '{1,1,0,32'd5,0,0, 0,32'd0,32'd0,0,0},
      '{1,0,0,32'd7,0,0, 0,32'd0,32'd0,0,0},
      '{1,0,1,32'd9,0,0, 0,32'd0,32'd0,0,0},
      '{0,0,0,32'd0,0,0, 1,32'd21,32'd3,0,0},
      '{0,0,0,32'd0,0,0, 0,32'd21,32'd3,0,0},
      '{1,1,1,32'hFFFFFFFF,0,0, 0,32'd21,32'd3,0,0},
      '{1,1,0,32'd1,0,0, 1,32'hFFFFFFFF,32'd1,0,0},
      '{1,0,1,32'd1,0,0, 0,32'hFFFFFFFF,32'd1,0,0},
      '{0,0,0,32'd0,0,0, 1,32'd2,32'd2,0,0},
      '{1,1,0,32'd3,0,0, 0,32'd2,32'd2,0,0},
      '{1,0,0,32'd4,0,0, 0,32'd2,32'd2,0,0},
      '{1,1,0,32'd10,0,0, 0,32'd2,32'd2,0,0},
      '{1,0,1,32'd1,0,0, 0,32'd2,32'd2,1,0},
      '{0,0,0,32'd0,0,0, 1,32'd11,32'd2,0,0},
      '{1,1,0,32'd8,0,0, 0,32'd11,32'd2,0,0},
      '{1,0,0,32'd9,0,1, 0,32'd11,32'd2,0,0},
      '{1,0,1,32'd5,0,0, 0,32'd11,32'd2,0,0},
      '{1,1,0,32'd2,0,0, 0,32'd11,32'd2,1,0},
      '{1,0,1,32'd2,0,0, 0,32'd11,32'd2,0,0},
      '{0,0,0,32'd0,0,0, 1,32'd4,32'd2,0,0},
      '{1,1,1,32'd6,1,0, 0,32'd4,32'd2,0,0},
      '{1,1,0,32'd100,1,0, 1,32'd6,32'd1,0,1},
      '{1,1,0,32'd100,1,0, 1,32'd6,32'd1,0,1},
      '{1,1,0,32'd100,1,0, 1,32'd6,32'd1,0,1},
      '{1,1,0,32'd100,1,0, 1,32'd6,32'd1,0,1},
      '{1,1,0,32'd100,0,0, 1,32'd6,32'd1,0,0},
      '{1,0,1,32'd5,0,0, 0,32'd6,32'd1,0,0},
      '{0,0,0,32'd0,0,0, 1,32'd105,32'd2,0,0},
      '{0,0,0,32'd0,0,0, 0,32'd105,32'd2,0,0}
    };
    step;
    step;
    rst = 0;
    chk_en = 1;
    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].f, tbl[i].l, tbl[i].d, tbl[i].b, tbl[i].a);
      @(negedge clk);
      #1;
      chk("t_mflags", cd_mflags, {tbl[i].ev[0] & tbl[i].b[0], tbl[i].ev[0], tbl[i].ev[0], tbl[i].ev[0]});
      chk("t_d0", cd_d0, tbl[i].ed0);
      chk("t_d1", cd_d1, tbl[i].ed1);
      chk("t_drop", frm_drop, tbl[i].edrop);
      chk("t_cu_bsy", cu_sflags[0], tbl[i].ecb);
      chk("t_cu_abt", cu_sflags[1], tbl[i].a);
      step;
    end
    drive(1, 1, 0, 200, 0, 0); step;
    drive(1, 0, 1, 100, 0, 0); step;
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk); #1;
    chk("wrap8_d0", d8_d0, 44);
    chk("wrap8_d1", d8_d1, 2);
    chk("wrap32_d0", cd_d0, 300);
    step;
    drive(1, 1, 0, 7, 0, 0); step;
    drive(1, 0, 0, 8, 0, 0); step;
    rst = 1;
    drive(0, 0, 0, 0, 0, 0); step;
    rst = 0;
    @(negedge clk); #1;
    chk("rst_d0", cd_d0, 0);
    chk("rst_d1", cd_d1, 0);
    chk("rst_mflags", cd_mflags, 0);
    chk("rst_drop", frm_drop, 0);
    step;
    drive(1, 1, 0, 1, 0, 0); step;
    drive(1, 0, 1, 2, 0, 0); step;
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk); #1;
    chk("post_rst_d0", cd_d0, 3);
    chk("post_rst_d1", cd_d1, 2);
    chk("post_rst_mflags", cd_mflags, 4'b0111);
    step;
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom % 300) == 0;
      drive(($urandom % 4) != 0, ($urandom % 4) == 0, ($urandom % 3) == 0, $urandom,
            ($urandom % 3) == 0, ($urandom % 40) == 0);
      step;
    end
    rst = 0;
    drive(0, 0, 0, 0, 0, 0);
    step;
    step;
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/frame_accum.md
Name: frame_accum

Overview:
- Streaming reducer placed directly downstream of cross_seqx2; consumes its framed (first..last) beat stream carrying cd_d0/cd_d1.
- Emits exactly one single-beat frame per input frame: cd_d0 = wrapping sum of d0 over the frame, cd_d1 = number of beats in the frame.
- Uses the codebase flag protocol: master flags {again, first, last, vld}, slave flags {abt, bsy}.

Parameters:
- W, 32, data width of d0/d1 and of the sum and beat count.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- uc_d0  input  W  upstream data, summed.
- uc_d1  input  W  upstream secondary data; accepted but not used in the result.
- uc_mflags  input  4  {uc_again, uc_first, uc_last, uc_vld}.
- cu_sflags  output  2  {cu_abt, cu_bsy}.
- cd_d0  output  W  frame sum, registered.
- cd_d1  output  W  frame beat count, registered.
- cd_mflags  output  4  {cd_again, cd_first, cd_last, cd_vld}.
- dc_sflags  input  2  {dc_abt, dc_bsy}.
- frm_drop  output  1  one-cycle pulse when a partial or orphan frame is discarded.

Behaviour:
- Clock and reset: single clock, clk. Reset is synchronous, active-high on rst, and overrides everything else.
- Reset values: state=ST_IDLE, acc=0, cnt=0, cd_d0=0, cd_d1=0, cd_vld=0, frm_drop=0.
- Transfer rules:
  - Upstream beat accepted iff uc_vld & ~cu_bsy.
  - Downstream beat consumed iff cd_vld & ~dc_bsy.
  - uc_again is ignored.
- Outputs:
  - cd_first = cd_last = cd_vld.
  - cd_again = cd_vld & dc_bsy.
  - cu_abt = dc_abt, combinational.
  - cu_bsy = (state==ST_OUT) & dc_bsy, so back-to-back frames are possible.
- Arithmetic: acc and cnt are W bits and wrap modulo 2^W; no saturation.
- States:
  - ST_IDLE (no frame open).
  - ST_ACC (frame open).
  - ST_OUT (result held on cd_*).
- ST_IDLE, accepted beat:
  - first & last: cd_d0=uc_d0, cd_d1=1, go to ST_OUT.
  - first & ~last: acc=uc_d0, cnt=1, go to ST_ACC.
  - ~first: beat discarded, frm_drop=1, stay in ST_IDLE.
- ST_ACC, accepted beat:
  - ~first & ~last: acc+=uc_d0, cnt+=1.
  - ~first & last: cd_d0=acc+uc_d0, cd_d1=cnt+1, go to ST_OUT.
  - first: partial frame dropped and frm_drop=1; the beat then starts a new frame exactly as in ST_IDLE (including first & last going to ST_OUT).
- ST_OUT:
  - cd_vld=1.
  - On ~dc_bsy the result is consumed. A beat accepted in the same cycle is processed as in ST_IDLE (next state ST_ACC or ST_OUT with new data). With no beat, go to ST_IDLE and cd_vld=0 next cycle.
  - dc_bsy holds cd_d0/cd_d1/cd_mflags stable.
- Latency: last beat accepted at cycle t gives cd_vld=1 with the result at t+1.
- Abort: dc_abt=1 in any cycle forces state=ST_IDLE, acc=0, cnt=0, cd_vld=0 next cycle. Any beat accepted in that cycle is discarded. frm_drop is not pulsed. dc_abt has priority over all transitions.
- Idle cycles (uc_vld=0) inside a frame do not alter acc/cnt.
- Reset mid-frame or mid-output discards everything with no frm_drop pulse.

Test Plan:
- Frame d0=5,7,9 (first on 5, last on 9), dc_bsy=0 -> one output cycle later: cd_d0=21, cd_d1=3, cd_mflags=4'b0111.
- Single beat first&last, d0=0xFFFFFFFF, followed by a frame 1,1 -> outputs (0xFFFFFFFF,1) then (2,2). cu_bsy never asserted with dc_bsy=0 (back-to-back).
- Result pending, dc_bsy=1 for 4 cycles -> cd_* stable, cd_again=1, cu_bsy=1, upstream beats not accepted. Release -> consumed once and next frame accepted that same cycle.
- Frame 3,4 then first again with d0=10 before last, then last d0=1 -> frm_drop pulses once; output is (11,2).
- Mid-frame dc_abt=1 for 1 cycle -> cu_abt=1 same cycle, no output produced. Next frame 2,2 yields (4,2).
- Sum wrap: W=8, frame 200,100 -> cd_d0=44, cd_d1=2. rst=1 mid-frame -> all outputs 0, next frame unaffected.
